// File: rtl/mwc_pkg.sv
// Shared types and constants for the memory-write checker: monitor state and failure codes.
package mwc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_t;

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_MISMATCH = 3'd1;
   localparam logic [2:0] FC_TIMEOUT  = 3'd2;
   localparam logic [2:0] FC_ILLEGAL  = 3'd3;

   // Width of a table index; a single-entry table still gets a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-write table: NUM_EXP address/data pairs, one synchronous write port,
// one asynchronous read port. Out-of-range indices neither write nor read.
module mwc_exp_table #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_EXP = 4,
   parameter int IDX_W   = 2,
   parameter int RD_W    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [RD_W-1:0]   rd_idx,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t entries_q [NUM_EXP];
   entry_t rd_entry;

   // NOTE: the table is cleared by reset because a freshly reset checker must
   // compare against all-zero entries; this keeps it in flops rather than RAM.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_EXP; i++) entries_q[i] <= '0;
      end else if (we) begin
         for (int i = 0; i < NUM_EXP; i++) begin
            if (wr_idx == IDX_W'(i)) entries_q[i] <= '{addr: wr_addr, data: wr_data};
         end
      end
   end

   always_comb begin
      rd_entry = '0;
      for (int i = 0; i < NUM_EXP; i++) begin
         if (rd_idx == RD_W'(i)) rd_entry = entries_q[i];
      end
   end

   assign rd_addr = rd_entry.addr;
   assign rd_data = rd_entry.data;

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor for the data-memory write port: matches observed writes against a
// programmable expected-write table, with optional strict ordering and a cycle watchdog.
module mem_write_checker
   import mwc_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_EXP = 4,
   parameter int STRICT  = 0,
   parameter int TIMEOUT = 1000,
   parameter int CNT_W   = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               exp_we,
   input  logic [idx_width(NUM_EXP)-1:0]      exp_idx,
   input  logic [ADDR_W-1:0]                  exp_addr,
   input  logic [DATA_W-1:0]                  exp_data,
   input  logic                               start,
   input  logic                               clear,
   input  logic                               mem_write,
   input  logic [ADDR_W-1:0]                  adr,
   input  logic [DATA_W-1:0]                  write_data,
   input  logic                               instr_invalid,
   output logic                               busy,
   output logic                               done,
   output logic                               pass,
   output logic [2:0]                         fail_code,
   output logic [$clog2(NUM_EXP+1)-1:0]       match_count,
   output logic [CNT_W-1:0]                   cycle_count,
   output logic [ADDR_W-1:0]                  fail_addr,
   output logic [DATA_W-1:0]                  fail_data
);

   localparam int IDX_W = idx_width(NUM_EXP);
   localparam int MC_W  = $clog2(NUM_EXP + 1);

   state_t            state_q, state_d;
   logic [MC_W-1:0]   match_q, match_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [2:0]        code_q, code_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic [DATA_W-1:0] fdata_q, fdata_d;

   logic              table_we;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic              entry_match;
   logic              last_entry;
   logic              timeout_hit;

   mwc_exp_table #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .NUM_EXP (NUM_EXP),
      .IDX_W   (IDX_W),
      .RD_W    (MC_W)
   ) u_table (
      .clk     (clk),
      .reset   (reset),
      .we      (table_we),
      .wr_idx  (exp_idx),
      .wr_addr (exp_addr),
      .wr_data (exp_data),
      .rd_idx  (match_q),
      .rd_addr (cur_addr),
      .rd_data (cur_data)
   );

   assign entry_match = mem_write && (adr == cur_addr) && (write_data == cur_data);
   assign last_entry  = (match_q == MC_W'(NUM_EXP - 1));
   // Compared at 64 bits so a narrow counter that saturates below TIMEOUT never aliases.
   assign timeout_hit = (64'(cyc_q) == 64'(TIMEOUT - 1));

   // NOTE: every signal driven here gets its default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      match_d  = match_q;
      cyc_d    = cyc_q;
      code_d   = code_q;
      faddr_d  = faddr_q;
      fdata_d  = fdata_q;
      table_we = 1'b0;

      unique case (state_q)
         IDLE: begin
            table_we = exp_we;
            if (start) begin
               state_d = RUN;
               match_d = '0;
               cyc_d   = '0;
               code_d  = FC_NONE;
               faddr_d = '0;
               fdata_d = '0;
            end
         end

         RUN: begin
            if (cyc_q != '1) cyc_d = cyc_q + 1'b1;

            if (instr_invalid) begin
               state_d = FAIL;
               code_d  = FC_ILLEGAL;
            end else if (entry_match && last_entry) begin
               match_d = match_q + 1'b1;
               state_d = PASS;
            end else begin
               if (entry_match) match_d = match_q + 1'b1;

               if (mem_write && !entry_match && (STRICT != 0)) begin
                  state_d = FAIL;
                  code_d  = FC_MISMATCH;
                  faddr_d = adr;
                  fdata_d = write_data;
               end else if (timeout_hit) begin
                  state_d = FAIL;
                  code_d  = FC_TIMEOUT;
               end
            end
         end

         PASS, FAIL: begin
            if (clear) begin
               state_d = IDLE;
               match_d = '0;
               cyc_d   = '0;
               code_d  = FC_NONE;
               faddr_d = '0;
               fdata_d = '0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples the values computed before this edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         match_q <= '0;
         cyc_q   <= '0;
         code_q  <= FC_NONE;
         faddr_q <= '0;
         fdata_q <= '0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
         cyc_q   <= cyc_d;
         code_q  <= code_d;
         faddr_q <= faddr_d;
         fdata_q <= fdata_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == PASS) || (state_q == FAIL);
   assign pass        = (state_q == PASS);
   assign fail_code   = code_q;
   assign match_count = match_q;
   assign cycle_count = cyc_q;
   assign fail_addr   = faddr_q;
   assign fail_data   = fdata_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: three instances cover subsequence mode,
// strict mode with a short watchdog, and a narrow saturating cycle counter.
module tb_mem_write_checker;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        exp_we = 1'b0;
   logic [1:0]  exp_idx = '0;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_data = '0;
   logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic        clear_a = 1'b0, clear_b = 1'b0, clear_c = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] adr = '0;
   logic [31:0] write_data = '0;
   logic        instr_invalid = 1'b0;

   logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
   logic [2:0]  fc_a, fc_b, fc_c;
   logic [0:0]  mc_a;
   logic [1:0]  mc_b, mc_c;
   logic [31:0] cc_a, cc_b;
   logic [3:0]  cc_c;
   logic [31:0] fa_a, fd_a, fa_b, fd_b, fa_c, fd_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(1), .STRICT(0), .TIMEOUT(1000), .CNT_W(32)) dut_a (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx[0:0]), .exp_addr(exp_addr),
      .exp_data(exp_data), .start(start_a), .clear(clear_a), .mem_write(mem_write), .adr(adr),
      .write_data(write_data), .instr_invalid(instr_invalid), .busy(busy_a), .done(done_a),
      .pass(pass_a), .fail_code(fc_a), .match_count(mc_a), .cycle_count(cc_a),
      .fail_addr(fa_a), .fail_data(fd_a));

   mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(3), .STRICT(1), .TIMEOUT(20), .CNT_W(32)) dut_b (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
      .exp_data(exp_data), .start(start_b), .clear(clear_b), .mem_write(mem_write), .adr(adr),
      .write_data(write_data), .instr_invalid(instr_invalid), .busy(busy_b), .done(done_b),
      .pass(pass_b), .fail_code(fc_b), .match_count(mc_b), .cycle_count(cc_b),
      .fail_addr(fa_b), .fail_data(fd_b));

   mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(2), .STRICT(0), .TIMEOUT(100), .CNT_W(4)) dut_c (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx[0:0]), .exp_addr(exp_addr),
      .exp_data(exp_data), .start(start_c), .clear(clear_c), .mem_write(mem_write), .adr(adr),
      .write_data(write_data), .instr_invalid(instr_invalid), .busy(busy_c), .done(done_c),
      .pass(pass_c), .fail_code(fc_c), .match_count(mc_c), .cycle_count(cc_c),
      .fail_addr(fa_c), .fail_data(fd_c));

   // Advance past one rising edge and settle; outputs are read 1 ns after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
      exp_we = 1'b1; exp_idx = idx; exp_addr = a; exp_data = d;
      cycle();
      exp_we = 1'b0;
   endtask

   task automatic drive_write(input logic we, input logic [31:0] a, input logic [31:0] d);
      mem_write = we; adr = a; write_data = d;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cycle(); cycle();
      reset = 1'b1;
      checks++; if (busy_b !== 1'b0 || done_b !== 1'b0 || pass_b !== 1'b0) begin
         errors++; $display("FAIL reset_flags busy/done/pass got %b%b%b want 000", busy_b, done_b, pass_b); end
      checks++; if (fc_b !== 3'd0 || mc_b !== 2'd0 || cc_b !== 32'd0) begin
         errors++; $display("FAIL reset_counts code/match/cycles got %0d/%0d/%0d want 0/0/0", fc_b, mc_b, cc_b); end
      checks++; if (fa_b !== 32'd0 || fd_b !== 32'd0) begin
         errors++; $display("FAIL reset_capture addr/data got %h/%h want 0/0", fa_b, fd_b); end
   endtask

   // Single expected write, non-strict; table write and start share a cycle.
   task automatic test_subsequence();
      exp_we = 1'b1; exp_idx = 2'd0; exp_addr = 32'd100; exp_data = 32'd8; start_a = 1'b1;
      cycle();
      exp_we = 1'b0; start_a = 1'b0;
      checks++; if (busy_a !== 1'b1 || mc_a !== 1'b0) begin
         errors++; $display("FAIL sub_start busy/match got %b/%0d want 1/0", busy_a, mc_a); end
      drive_write(1'b1, 32'd96, 32'd7);
      cycle();
      checks++; if (mc_a !== 1'b0 || busy_a !== 1'b1) begin
         errors++; $display("FAIL sub_ignore match/busy got %0d/%b want 0/1", mc_a, busy_a); end
      drive_write(1'b1, 32'd100, 32'd8);
      cycle();
      drive_write(1'b0, 32'd0, 32'd0);
      checks++; if (mc_a !== 1'b1 || pass_a !== 1'b1 || done_a !== 1'b1) begin
         errors++; $display("FAIL sub_pass match/pass/done got %0d/%b/%b want 1/1/1", mc_a, pass_a, done_a); end
      checks++; if (fc_a !== 3'd0) begin
         errors++; $display("FAIL sub_code got %0d want 0", fc_a); end
      drive_write(1'b1, 32'd1, 32'd2); instr_invalid = 1'b1;
      cycle();
      drive_write(1'b0, 32'd0, 32'd0); instr_invalid = 1'b0;
      checks++; if (pass_a !== 1'b1 || fc_a !== 3'd0) begin
         errors++; $display("FAIL sub_hold pass/code got %b/%0d want 1/0", pass_a, fc_a); end
      clear_a = 1'b1;
      cycle();
      clear_a = 1'b0;
      checks++; if (done_a !== 1'b0 || mc_a !== 1'b0 || busy_a !== 1'b0) begin
         errors++; $display("FAIL sub_clear done/match/busy got %b/%0d/%b want 0/0/0", done_a, mc_a, busy_a); end
   endtask

   task automatic test_strict_mismatch();
      load(2'd0, 32'h10, 32'd1);
      load(2'd1, 32'h14, 32'd2);
      load(2'd2, 32'h18, 32'd3);
      start_b = 1'b1;
      cycle();
      start_b = 1'b0;
      drive_write(1'b1, 32'h10, 32'd1);
      cycle();
      checks++; if (mc_b !== 2'd1) begin
         errors++; $display("FAIL strict_first match got %0d want 1", mc_b); end
      drive_write(1'b1, 32'h18, 32'd3);
      cycle();
      drive_write(1'b0, 32'd0, 32'd0);
      checks++; if (done_b !== 1'b1 || pass_b !== 1'b0 || busy_b !== 1'b0 || fc_b !== 3'd1) begin
         errors++; $display("FAIL strict_fail done/pass/busy/code got %b/%b/%b/%0d want 1/0/0/1", done_b, pass_b, busy_b, fc_b); end
      checks++; if (fa_b !== 32'h18 || fd_b !== 32'd3 || mc_b !== 2'd1) begin
         errors++; $display("FAIL strict_capture addr/data/match got %h/%0d/%0d want 18/3/1", fa_b, fd_b, mc_b); end
   endtask

   // Clear after FAIL, rerun on the kept table; table writes and start during RUN are ignored.
   task automatic test_clear_restart();
      clear_b = 1'b1;
      cycle();
      clear_b = 1'b0;
      checks++; if (done_b !== 1'b0 || fc_b !== 3'd0 || fa_b !== 32'd0 || fd_b !== 32'd0 || mc_b !== 2'd0) begin
         errors++; $display("FAIL clear_status done/code/addr/data/match got %b/%0d/%h/%h/%0d want 0/0/0/0/0", done_b, fc_b, fa_b, fd_b, mc_b); end
      start_b = 1'b1;
      cycle();
      start_b = 1'b0;
      checks++; if (busy_b !== 1'b1 || cc_b !== 32'd0) begin
         errors++; $display("FAIL restart_cycles busy/cycles got %b/%0d want 1/0", busy_b, cc_b); end
      drive_write(1'b1, 32'h10, 32'd1);
      cycle();
      drive_write(1'b1, 32'h14, 32'd2);
      exp_we = 1'b1; exp_idx = 2'd2; exp_addr = 32'h55; exp_data = 32'h66; start_b = 1'b1;
      cycle();
      exp_we = 1'b0; start_b = 1'b0;
      checks++; if (mc_b !== 2'd2 || busy_b !== 1'b1) begin
         errors++; $display("FAIL restart_mid match/busy got %0d/%b want 2/1", mc_b, busy_b); end
      drive_write(1'b1, 32'h18, 32'd3);
      cycle();
      drive_write(1'b0, 32'd0, 32'd0);
      checks++; if (pass_b !== 1'b1 || mc_b !== 2'd3 || cc_b !== 32'd3) begin
         errors++; $display("FAIL restart_pass pass/match/cycles got %b/%0d/%0d want 1/3/3", pass_b, mc_b, cc_b); end
      clear_b = 1'b1;
      cycle();
      clear_b = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      start_b = 1'b1;
      cycle();
      start_b = 1'b0;
      n = 0;
      while (busy_b === 1'b1 && n < 40) begin
         cycle();
         n++;
      end
      checks++; if (n != 20) begin
         errors++; $display("FAIL timeout_busy_cycles got %0d want 20", n); end
      checks++; if (done_b !== 1'b1 || pass_b !== 1'b0 || fc_b !== 3'd2 || cc_b !== 32'd20) begin
         errors++; $display("FAIL timeout_result done/pass/code/cycles got %b/%b/%0d/%0d want 1/0/2/20", done_b, pass_b, fc_b, cc_b); end
      checks++; if (fa_b !== 32'd0 || fd_b !== 32'd0) begin
         errors++; $display("FAIL timeout_capture addr/data got %h/%h want 0/0", fa_b, fd_b); end
      clear_b = 1'b1;
      cycle();
      clear_b = 1'b0;
   endtask

   // Final matching write lands on the 20th RUN cycle: match wins over timeout.
   task automatic test_match_on_timeout();
      start_b = 1'b1;
      cycle();
      start_b = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 1)       drive_write(1'b1, 32'h10, 32'd1);
         else if (k == 2)  drive_write(1'b1, 32'h14, 32'd2);
         else if (k == 20) drive_write(1'b1, 32'h18, 32'd3);
         else              drive_write(1'b0, 32'd0, 32'd0);
         cycle();
         if (k == 19) begin
            checks++; if (busy_b !== 1'b1 || mc_b !== 2'd2) begin
               errors++; $display("FAIL edge_pre busy/match got %b/%0d want 1/2", busy_b, mc_b); end
         end
      end
      drive_write(1'b0, 32'd0, 32'd0);
      checks++; if (pass_b !== 1'b1 || fc_b !== 3'd0 || mc_b !== 2'd3 || cc_b !== 32'd20) begin
         errors++; $display("FAIL edge_pass pass/code/match/cycles got %b/%0d/%0d/%0d want 1/0/3/20", pass_b, fc_b, mc_b, cc_b); end
      clear_b = 1'b1;
      cycle();
      clear_b = 1'b0;
   endtask

   task automatic test_illegal();
      start_b = 1'b1;
      cycle();
      start_b = 1'b0;
      drive_write(1'b1, 32'h10, 32'd1); instr_invalid = 1'b1;
      cycle();
      drive_write(1'b0, 32'd0, 32'd0); instr_invalid = 1'b0;
      checks++; if (done_b !== 1'b1 || pass_b !== 1'b0 || fc_b !== 3'd3) begin
         errors++; $display("FAIL illegal_result done/pass/code got %b/%b/%0d want 1/0/3", done_b, pass_b, fc_b); end
      checks++; if (mc_b !== 2'd0 || fa_b !== 32'd0 || cc_b !== 32'd1) begin
         errors++; $display("FAIL illegal_state match/addr/cycles got %0d/%h/%0d want 0/0/1", mc_b, fa_b, cc_b); end
      clear_b = 1'b1;
      cycle();
      clear_b = 1'b0;
   endtask

   // Reset mid-RUN after one match: outputs cleared and the table zeroed.
   task automatic test_reset_mid_run();
      start_b = 1'b1;
      cycle();
      start_b = 1'b0;
      drive_write(1'b1, 32'h10, 32'd1);
      cycle();
      drive_write(1'b0, 32'd0, 32'd0);
      checks++; if (mc_b !== 2'd1 || busy_b !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre match/busy got %0d/%b want 1/1", mc_b, busy_b); end
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      checks++; if (busy_b !== 1'b0 || done_b !== 1'b0 || mc_b !== 2'd0 || cc_b !== 32'd0 || fc_b !== 3'd0) begin
         errors++; $display("FAIL rstmid_clear busy/done/match/cycles/code got %b/%b/%0d/%0d/%0d want 0/0/0/0/0", busy_b, done_b, mc_b, cc_b, fc_b); end
      start_b = 1'b1;
      cycle();
      start_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_write(1'b1, 32'd0, 32'd0);
         cycle();
      end
      drive_write(1'b0, 32'd0, 32'd0);
      checks++; if (pass_b !== 1'b1 || mc_b !== 2'd3 || fc_b !== 3'd0) begin
         errors++; $display("FAIL rstmid_zero_table pass/match/code got %b/%0d/%0d want 1/3/0", pass_b, mc_b, fc_b); end
      clear_b = 1'b1;
      cycle();
      clear_b = 1'b0;
   endtask

   // 4-bit counter with TIMEOUT=100: counter pins at 15 and the watchdog never fires.
   task automatic test_saturation();
      start_c = 1'b1;
      cycle();
      start_c = 1'b0;
      repeat (20) cycle();
      checks++; if (busy_c !== 1'b1 || cc_c !== 4'hF) begin
         errors++; $display("FAIL sat_count busy/cycles got %b/%0d want 1/15", busy_c, cc_c); end
      instr_invalid = 1'b1;
      cycle();
      instr_invalid = 1'b0;
      checks++; if (fc_c !== 3'd3 || done_c !== 1'b1 || cc_c !== 4'hF) begin
         errors++; $display("FAIL sat_end code/done/cycles got %0d/%b/%0d want 3/1/15", fc_c, done_c, cc_c); end
      clear_c = 1'b1;
      cycle();
      clear_c = 1'b0;
      checks++; if (cc_c !== 4'd0 || done_c !== 1'b0) begin
         errors++; $display("FAIL sat_clear cycles/done got %0d/%b want 0/0", cc_c, done_c); end
   endtask

   initial begin
      #1;
      test_reset();
      test_subsequence();
      test_strict_mismatch();
      test_clear_restart();
      test_timeout();
      test_match_on_timeout();
      test_illegal();
      test_reset_mid_run();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
